// File: rtl/reset_gen_if.sv
// ---------------------------------------------------------------------------
// reset_gen_if
// Groups the reset generator's software handshake and its reset/status
// outputs. The clock and raw reset stay plain ports on reset_gen.
//
// Signals:
//   sw_req_i     software reset request (level, held until sw_ack_o)
//   sw_ack_o     one-cycle pulse: software reset completed
//   rst_no       generated reset, active-low
//   rst_po       generated reset, active-high (always ~rst_no)
//   busy_o       1 while the generator is not in RUN
//   rst_count_o  completed software resets (saturating, optional)
//
// Modports:
//   master  the reset consumer / software requester
//   slave   the reset generator itself
// ---------------------------------------------------------------------------
interface reset_gen_if;
  logic       sw_req_i;
  logic       sw_ack_o;
  logic       rst_no;
  logic       rst_po;
  logic       busy_o;
  logic [7:0] rst_count_o;

  modport master (
    output sw_req_i,
    input  sw_ack_o, rst_no, rst_po, busy_o, rst_count_o
  );

  modport slave (
    input  sw_req_i,
    output sw_ack_o, rst_no, rst_po, busy_o, rst_count_o
  );
endinterface

// File: rtl/reset_gen.sv
// ---------------------------------------------------------------------------
// reset_gen
// Clean reset generator. Takes a clock and a raw asynchronous active-low
// reset and produces a reset with asynchronous assertion and synchronous,
// stretched deassertion. A level request / pulse ack software reset can
// re-assert the output reset for SW_CYCLES cycles while running.
//
// Parameters:
//   SYNC_STAGES  deassertion synchronizer depth (>= 2)
//   HOLD_CYCLES  cycles reset is held after the synchronizer releases (>= 1)
//   SW_CYCLES    cycles reset is asserted per software request (>= 1)
//
// Ports:
//   clk_i   clock
//   rst_ni  raw reset, asynchronous, active-low
//   bus     reset_gen_if.slave: sw_req_i in; sw_ack_o, rst_no, rst_po,
//           busy_o, rst_count_o out
//
// Optional feature: define RESET_GEN_CNT_EN to get a saturating 8-bit count
// of completed software resets on rst_count_o; otherwise it reads 8'h00.
// ---------------------------------------------------------------------------
module reset_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int SW_CYCLES   = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  reset_gen_if.slave bus
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > SW_CYCLES) ? HOLD_CYCLES : SW_CYCLES;
  // cnt only has to reach MAX_CYCLES-1 before leaving its state
  localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_HOLD,
    ST_RUN,
    ST_SW_RST
  } state_t;

  // -------------------------------------------------------------------------
  // Deassertion synchronizer: shifts in 1'b1, cleared asynchronously.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   sync_q;

  assign sync_next[0] = 1'b1;
  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      assign sync_next[gi] = sync_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= sync_next;
    end
  end

  assign sync_q = sync_reg[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             rst_n_reg;
  logic             ack_reg, ack_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= ST_ASSERT;
      cnt_reg   <= '0;
      rst_n_reg <= 1'b0;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      // Registered from the next state so rst_no tracks state_reg == RUN
      // exactly, without a decode glitch on the output.
      rst_n_reg <= (state_next == ST_RUN);
      ack_reg   <= ack_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ack_next   = 1'b0;
    unique case (state_reg)
      ST_ASSERT: begin
        if (sync_q) begin
          state_next = ST_HOLD;
          cnt_next   = '0;
        end
      end
      ST_HOLD: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == HOLD_LAST) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // The ack cycle is spent in RUN with the request ignored, so a
        // requester that drops sw_req_i on seeing the ack gets one reset.
        if (bus.sw_req_i && !ack_reg) begin
          state_next = ST_SW_RST;
          cnt_next   = '0;
        end
      end
      ST_SW_RST: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == SW_LAST) begin
          state_next = ST_RUN;
          ack_next   = 1'b1;
        end
      end
      default: begin
        state_next = ST_ASSERT;
      end
    endcase
  end

  assign bus.rst_no   = rst_n_reg;
  assign bus.rst_po   = ~rst_n_reg;
  assign bus.busy_o   = (state_reg != ST_RUN);
  assign bus.sw_ack_o = ack_reg;

  // -------------------------------------------------------------------------
  // Completed software reset counter
  // -------------------------------------------------------------------------
`ifdef RESET_GEN_CNT_EN
  logic [7:0] count_reg;

  // Counts on the same edge that raises sw_ack_o, so the new value is
  // visible during the ack cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_reg <= 8'h00;
    end else if (ack_next && (count_reg != 8'hFF)) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  assign bus.rst_count_o = count_reg;
`else
  assign bus.rst_count_o = 8'h00;
`endif

endmodule

// File: tb/tb_reset_gen.sv
// ---------------------------------------------------------------------------
// tb_reset_gen
// Self-checking bench for reset_gen. Two instances share clk/rst_ni:
//   dut_a  default parameters (2/16/8)
//   dut_b  SYNC_STAGES=3, HOLD_CYCLES=1 (request tied low)
// A table of vectors covers a single software reset cycle by cycle;
// hand-written sequences cover power-on timing, a request held through HOLD,
// an abort in the middle of SW_RST, and 300 back-to-back requests.
// ---------------------------------------------------------------------------
module tb_reset_gen;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  reset_gen_if bus_a ();
  reset_gen_if bus_b ();

  reset_gen dut_a (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus_a)
  );

  reset_gen #(
    .SYNC_STAGES (3),
    .HOLD_CYCLES (1),
    .SW_CYCLES   (8)
  ) dut_b (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus_b)
  );

  typedef struct {
    logic       req;
    logic       exp_rst_n;
    logic       exp_busy;
    logic       exp_ack;
    logic [7:0] exp_cnt;   // completed resets if the counter is built in
  } vec_t;

  vec_t sw_vec [11];

  function automatic logic [7:0] cnt_exp(input int n);
`ifdef RESET_GEN_CNT_EN
    return (n > 255) ? 8'd255 : 8'(n);
`else
    return 8'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Releases rst_ni before edge 1 and checks both instances up to edge 19.
  // With req_in_hold set, dut_a's request is raised during HOLD (after edge 5).
  task automatic por_run(input logic req_in_hold);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int e = 1; e <= 19; e++) begin
      step();
      chk("por_a_rst_no", bus_a.rst_no, (e >= 19));
      chk("por_a_rst_po", bus_a.rst_po, (e < 19));
      chk("por_a_busy",   bus_a.busy_o, (e < 19));
      chk("por_a_ack",    bus_a.sw_ack_o, 1'b0);
      chk("por_b_rst_no", bus_b.rst_no, (e >= 5));
      chk("por_b_rst_po", bus_b.rst_po, (e < 5));
      if (req_in_hold && e == 5) bus_a.sw_req_i = 1'b1;
    end
    $display("por: rst_no_a=%b rst_no_b=%b after edge 19", bus_a.rst_no, bus_b.rst_no);
  endtask

  task automatic pull_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    step();
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    int last_ack_cyc;
    int busy_cnt;
    int cyc;

    //                req exp_rst_n exp_busy exp_ack exp_cnt
    sw_vec[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
    for (int i = 1; i <= 7; i++) sw_vec[i] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
    sw_vec[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd1};
    sw_vec[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
    sw_vec[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1};

    bus_a.sw_req_i = 1'b0;
    bus_b.sw_req_i = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_a_rst_no", bus_a.rst_no, 1'b0);
    chk("rst_a_rst_po", bus_a.rst_po, 1'b1);
    chk("rst_a_busy",   bus_a.busy_o, 1'b1);
    chk("rst_a_ack",    bus_a.sw_ack_o, 1'b0);
    chk("rst_a_count",  bus_a.rst_count_o, 8'd0);
    chk("rst_b_rst_no", bus_b.rst_no, 1'b0);
    $display("reset: rst_no=%b busy=%b", bus_a.rst_no, bus_a.busy_o);

    // Power-on sequence, both parameter sets
    por_run(1'b0);
    step();
    step();

    // Single software reset, table driven
    for (int i = 0; i < 11; i++) begin
      bus_a.sw_req_i = sw_vec[i].req;
      step();
      chk("vec_rst_no", bus_a.rst_no, sw_vec[i].exp_rst_n);
      chk("vec_rst_po", bus_a.rst_po, !sw_vec[i].exp_rst_n);
      chk("vec_busy",   bus_a.busy_o, sw_vec[i].exp_busy);
      chk("vec_ack",    bus_a.sw_ack_o, sw_vec[i].exp_ack);
      chk("vec_count",  bus_a.rst_count_o, cnt_exp(int'(sw_vec[i].exp_cnt)));
      $display("vec %0d: req=%b rst_no=%b busy=%b ack=%b cnt=%0d", i, sw_vec[i].req,
               bus_a.rst_no, bus_a.busy_o, bus_a.sw_ack_o, bus_a.rst_count_o);
    end

    // Abort in SW_RST at cnt=3
    bus_a.sw_req_i = 1'b1;
    step();
    chk("abort_enter", bus_a.rst_no, 1'b0);
    step();
    step();
    step();
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    chk("abort_rst_no", bus_a.rst_no, 1'b0);
    chk("abort_rst_po", bus_a.rst_po, 1'b1);
    chk("abort_busy",   bus_a.busy_o, 1'b1);
    chk("abort_ack",    bus_a.sw_ack_o, 1'b0);
    chk("abort_count",  bus_a.rst_count_o, 8'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("abort_hold_ack", bus_a.sw_ack_o, 1'b0);
      chk("abort_hold_rst", bus_a.rst_no, 1'b0);
    end
    bus_a.sw_req_i = 1'b0;
    $display("abort: rst_no=%b count=%0d", bus_a.rst_no, bus_a.rst_count_o);
    por_run(1'b0);
    chk("abort_post_count", bus_a.rst_count_o, 8'd0);

    // Request raised during HOLD: waits for RUN, then SW_RST on edge 20
    pull_reset();
    por_run(1'b1);
    step();
    chk("hold_e20_rst_no", bus_a.rst_no, 1'b0);
    chk("hold_e20_busy",   bus_a.busy_o, 1'b1);
    for (int e = 21; e <= 27; e++) begin
      step();
      chk("hold_low_rst_no", bus_a.rst_no, 1'b0);
      chk("hold_low_ack",    bus_a.sw_ack_o, 1'b0);
    end
    step();
    chk("hold_e28_ack",    bus_a.sw_ack_o, 1'b1);
    chk("hold_e28_rst_no", bus_a.rst_no, 1'b1);
    chk("hold_e28_count",  bus_a.rst_count_o, cnt_exp(1));
    bus_a.sw_req_i = 1'b0;
    step();
    chk("hold_e29_ack", bus_a.sw_ack_o, 1'b0);
    $display("hold: ack seen at edge 28, count=%0d", bus_a.rst_count_o);

    // 300 back-to-back requests with the request held high
    pull_reset();
    por_run(1'b0);
    step();
    bus_a.sw_req_i = 1'b1;
    acks = 0;
    last_ack_cyc = 0;
    busy_cnt = 0;
    cyc = 0;
    while (acks < 300 && cyc < 4000) begin
      step();
      cyc++;
      if (bus_a.busy_o) busy_cnt++;
      if (bus_a.sw_ack_o) begin
        acks++;
        chk("b2b_busy_len", 8'(busy_cnt), 8'd8);
        if (acks > 1) chk("b2b_period", 8'(cyc - last_ack_cyc), 8'd10);
        chk("b2b_count", bus_a.rst_count_o, cnt_exp(acks));
        $display("b2b ack %0d: cycle=%0d count=%0d", acks, cyc, bus_a.rst_count_o);
        last_ack_cyc = cyc;
        busy_cnt = 0;
      end
    end
    if (acks < 300) chk("b2b_timeout_acks", 8'(acks), 8'(300));
    bus_a.sw_req_i = 1'b0;
    step();
    step();
    chk("b2b_final_count", bus_a.rst_count_o, cnt_exp(300));
    chk("b2b_final_rst_no", bus_a.rst_no, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
